col_drain_arbiter: RTL and testbench

- Round-robin scheduler that drains the per-column output buffers of the systolic array through one shared top-level result port.
- Issues single-cycle read strobes to column output controllers.
- Registers the selected result with column/row tags and counts results per tile.
- Sits between the COLS column output controllers and the top-level result interface.

---
 rtl/col_drain_pkg.sv | 21 ++
 rtl/col_drain_arbiter_rr.sv | 47 ++++
 rtl/col_drain_arbiter.sv | 159 +++++++++++++++
 tb/tb_col_drain_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/col_drain_pkg.sv
// Shared definitions for the column drain arbiter.
//   state_t   : drain FSM states.
//   idx_width : width of an index into n items (at least 1 bit).
//   cnt_width : width of a counter that must reach n inclusive.
package col_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/col_drain_arbiter_rr.sv
// Combinational round-robin picker.
// Scans the request vector starting at ptr and wrapping modulo COLS.
// The first set request wins.
// Ports:
//   req     : request vector, one bit per column
//   ptr     : index where the scan starts (must be < COLS)
//   gnt     : one-hot grant
//   gnt_idx : index of the granted column
//   gnt_any : some request was granted
module rr_arbiter #(
  parameter int COLS = 8,
  parameter int PW   = 3
) (
  input  logic [COLS-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [COLS-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            gnt_any
);

  localparam logic [PW:0] COLS_W = (PW+1)'(COLS);

  logic [PW:0]   sum;
  logic [PW-1:0] j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    j       = '0;
    for (int i = 0; i < COLS; i++) begin
      // ptr < COLS, so a single conditional subtract implements the wrap.
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= COLS_W) begin
        sum = sum - COLS_W;
      end
      j = sum[PW-1:0];
      if (!gnt_any && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = j;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/col_drain_arbiter.sv
// Round-robin drain of the per-column output buffers into one result port.
// Ports:
//   clk, rstn  : clock (rising edge); asynchronous active-low reset
//   col_data   : head result of each column controller
//   col_valid  : column has an unread result
//   col_read   : one-hot pop strobe, combinational in the grant cycle
//   tile_start : pulse in IDLE that starts draining a tile
//   out_data/out_col/out_row/out_valid : registered result with tags
//   out_ready  : downstream accepts; a transfer happens when valid && ready
//   busy       : high in DRAIN or DONE
//   tile_done  : one-cycle pulse after the last result of a tile transfers
module col_drain_arbiter
  import col_drain_pkg::*;
#(
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int OUTWIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [OUTWIDTH-1:0]     col_data [0:COLS-1],
  input  logic [COLS-1:0]         col_valid,
  output logic [COLS-1:0]         col_read,
  input  logic                    tile_start,
  output logic [OUTWIDTH-1:0]     out_data,
  output logic [$clog2(COLS)-1:0] out_col,
  output logic [$clog2(ROWS)-1:0] out_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    tile_done
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int CNT_W = cnt_width(ROWS);
  localparam int TOT_W = cnt_width(ROWS * COLS);

  localparam logic [CNT_W-1:0] ROWS_C   = CNT_W'(ROWS);
  localparam logic [TOT_W-1:0] LAST_C   = TOT_W'(ROWS * COLS - 1);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS - 1);

  typedef struct packed {
    logic [OUTWIDTH-1:0] data;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
  } result_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] row_cnt_reg [COLS];
  logic [TOT_W-1:0] total_reg;
  logic [COL_W-1:0] rr_ptr_reg;
  result_t          result_reg;
  logic             out_valid_reg;

  logic [COLS-1:0]  eligible;
  logic [COLS-1:0]  gnt;
  logic [COL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             can_load;
  logic             grant;
  logic             xfer;
  logic             start_tile;

  // A column that has already delivered ROWS results is masked off even if
  // its valid stays high, so an upstream count wrap cannot over-drain it.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_elig
    assign eligible[gi] = col_valid[gi] && (row_cnt_reg[gi] < ROWS_C);
  end

  rr_arbiter #(
    .COLS (COLS),
    .PW   (COL_W)
  ) u_rr (
    .req     (eligible),
    .ptr     (rr_ptr_reg),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign can_load   = !out_valid_reg || out_ready;
  assign grant      = (state_reg == DRAIN) && can_load && gnt_any;
  assign xfer       = out_valid_reg && out_ready;
  assign start_tile = (state_reg == IDLE) && tile_start;

  always_comb begin
    state_next = state_reg;
    col_read   = '0;
    if (grant) begin
      col_read = gnt;
    end
    case (state_reg)
      IDLE:    if (tile_start) state_next = DRAIN;
      // total counts completed transfers, so the tile ends when the
      // transfer that brings it to ROWS*COLS happens.
      DRAIN:   if (xfer && (total_reg == LAST_C)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < COLS; c++) begin
        row_cnt_reg[c] <= '0;
      end
      total_reg <= '0;
    end else if (start_tile) begin
      for (int c = 0; c < COLS; c++) begin
        row_cnt_reg[c] <= '0;
      end
      total_reg <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (col_read[c]) begin
          row_cnt_reg[c] <= row_cnt_reg[c] + 1'b1;
        end
      end
      if ((state_reg == DRAIN) && xfer) begin
        total_reg <= total_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result_reg    <= '0;
      out_valid_reg <= 1'b0;
      rr_ptr_reg    <= '0;
    end else if (grant) begin
      // A grant may coincide with the transfer of the previous result;
      // the register then simply reloads and stays valid.
      result_reg.data <= col_data[gnt_idx];
      result_reg.col  <= gnt_idx;
      result_reg.row  <= row_cnt_reg[gnt_idx][ROW_W-1:0];
      out_valid_reg   <= 1'b1;
      rr_ptr_reg      <= (gnt_idx == COL_MAX) ? '0 : gnt_idx + 1'b1;
    end else if (xfer) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = result_reg.data;
  assign out_col   = result_reg.col;
  assign out_row   = result_reg.row;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != IDLE);
  assign tile_done = (state_reg == DONE);

endmodule

// File: tb/tb_col_drain_arbiter.sv
// Self-checking bench for col_drain_arbiter (COLS=4, ROWS=8, OUTWIDTH=32).
// Upstream columns are modelled as counters: col_data[c] = 0x100*c + pops(c).
module tb_col_drain_arbiter;

  localparam int COLS = 4;
  localparam int ROWS = 8;
  localparam int W    = 32;
  localparam int NRES = COLS * ROWS;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [W-1:0]    col_data [0:COLS-1];
  logic [COLS-1:0] col_valid;
  logic [COLS-1:0] col_read;
  logic            tile_start = 1'b0;
  logic [W-1:0]    out_data;
  logic [1:0]      out_col;
  logic [2:0]      out_row;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            busy;
  logic            tile_done;

  always #5 clk = ~clk;

  col_drain_arbiter #(.COLS(COLS), .ROWS(ROWS), .OUTWIDTH(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .col_data   (col_data),
    .col_valid  (col_valid),
    .col_read   (col_read),
    .tile_start (tile_start),
    .out_data   (out_data),
    .out_col    (out_col),
    .out_row    (out_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .tile_done  (tile_done)
  );

  // ---------------- upstream column model ----------------
  int              served [COLS];
  logic            clr_served = 1'b0;
  logic [COLS-1:0] en_mask = '0;
  logic            sparse = 1'b0;
  int              cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < COLS; c++) begin
      if (clr_served) served[c] <= 0;
      else if (col_read[c]) served[c] <= served[c] + 1;
    end
  end

  always_comb begin
    col_valid = '0;
    for (int c = 0; c < COLS; c++) begin
      col_data[c]  = 32'(32'h100 * c + served[c]);
      col_valid[c] = en_mask[c] && !(sparse && (c == 2) && (cyc % 3 != 0));
    end
  end

  // ---------------- transfer monitor ----------------
  typedef struct {
    int         col;
    int         row;
    logic [31:0] data;
    int         cyc;
  } xfer_t;

  xfer_t log_q[$];
  int    done_cnt = 0;
  int    done_cyc = -1;

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      log_q.push_back('{int'(out_col), int'(out_row), out_data, cyc});
      $display("[TB] xfer #%0d col=%0d row=%0d data=%08h", log_q.size(), out_col, out_row, out_data);
    end
    if (rstn && tile_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- expected-value tables ----------------
  typedef struct {
    int          col;
    int          row;
    logic [31:0] data;
  } vec_t;

  vec_t basic_tbl [NRES];
  vec_t fair_tbl  [NRES];
  vec_t rot_tbl   [NRES];
  vec_t cur_tbl   [NRES];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_upstream();
    clr_served = 1'b1;
    step(1);
    clr_served = 1'b0;
  endtask

  task automatic start_tile();
    log_q.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    tile_start = 1'b1;
    step(1);
    tile_start = 1'b0;
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (log_q.size() < n && k < 200) begin
      step(1);
      k++;
    end
    check({tag, " reached transfer count"}, 64'(log_q.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      step(1);
      k++;
    end
    check({tag, " tile_done seen"}, 64'(done_cnt != 0), 64'd1);
    step(4);
    check({tag, " tile_done pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " busy after done"}, 64'(busy), 64'd0);
  endtask

  task automatic compare_log(input string tag);
    check({tag, " count"}, 64'(log_q.size()), 64'(NRES));
    for (int k = 0; k < NRES; k++) begin
      if (k < log_q.size()) begin
        check($sformatf("%s[%0d] col/row/data", tag, k),
              {8'(log_q[k].col), 8'(log_q[k].row), log_q[k].data},
              {8'(cur_tbl[k].col), 8'(cur_tbl[k].row), cur_tbl[k].data});
      end
    end
  endtask

  initial begin
    int gaps;
    int next_row [COLS];
    logic [31:0] h_data;
    logic [1:0]  h_col;
    logic [2:0]  h_row;

    // Basic / back-pressure / post-reset order: 0,1,2,3 repeating.
    // Fairness: 1,3 alternating for 16, then 0,2 alternating.
    // Restart after fairness tile: rr_ptr continues at 3 -> 3,0,1,2 repeating.
    for (int k = 0; k < NRES; k++) begin
      basic_tbl[k] = '{k % 4, k / 4, 32'(32'h100 * (k % 4) + k / 4)};
      rot_tbl[k]   = '{(3 + k) % 4, k / 4, 32'(32'h100 * ((3 + k) % 4) + k / 4)};
      if (k < 16)
        fair_tbl[k] = '{(k % 2) ? 3 : 1, k / 2, 32'(32'h100 * ((k % 2) ? 3 : 1) + k / 2)};
      else
        fair_tbl[k] = '{((k - 16) % 2) ? 2 : 0, (k - 16) / 2,
                        32'(32'h100 * (((k - 16) % 2) ? 2 : 0) + (k - 16) / 2)};
    end

    // ---------- reset state ----------
    step(2);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset col_read", 64'(col_read), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset tile_done", 64'(tile_done), 64'd0);
    rstn = 1'b1;
    step(1);

    // ---------- basic drain ----------
    en_mask   = 4'hF;
    out_ready = 1'b1;
    start_tile();
    check("basic first col_read", 64'(col_read), 64'h1);
    check("basic busy in drain", 64'(busy), 64'd1);
    step(1);
    check("basic latency out_valid", 64'(out_valid), 64'd1);
    check("basic first out_col", 64'(out_col), 64'd0);
    check("basic first out_data", 64'(out_data), 64'd0);
    wait_done(100, "basic");
    cur_tbl = basic_tbl;
    compare_log("basic");
    gaps = 0;
    for (int k = 1; k < log_q.size(); k++)
      if (log_q[k].cyc != log_q[k-1].cyc + 1) gaps++;
    check("basic consecutive transfers", 64'(gaps), 64'd0);
    if (log_q.size() > 0)
      check("basic tile_done timing", 64'(done_cyc), 64'(log_q[log_q.size()-1].cyc + 1));

    // ---------- back-pressure ----------
    clear_upstream();
    start_tile();
    wait_log(10, "bp");
    out_ready = 1'b0;
    step(1);
    h_data = out_data;
    h_col  = out_col;
    h_row  = out_row;
    check("bp stall out_valid", 64'(out_valid), 64'd1);
    for (int s = 0; s < 5; s++) begin
      check($sformatf("bp stall %0d col_read", s), 64'(col_read), 64'd0);
      check($sformatf("bp stall %0d tags/data", s),
            {8'(out_col), 8'(out_row), out_data}, {8'(h_col), 8'(h_row), h_data});
      step(1);
    end
    out_ready = 1'b1;
    #1;
    check("bp release grant onehot", 64'($onehot(col_read)), 64'd1);
    wait_done(100, "bp");
    compare_log("bp");

    // ---------- round-robin fairness ----------
    clear_upstream();
    en_mask = 4'b1010;
    start_tile();
    step(25);
    check("fair partial count", 64'(log_q.size()), 64'd16);
    check("fair saturated col_read", 64'(col_read), 64'd0);
    check("fair saturated out_valid", 64'(out_valid), 64'd0);
    check("fair still busy", 64'(busy), 64'd1);
    check("fair no early done", 64'(done_cnt), 64'd0);
    en_mask = 4'hF;
    wait_done(100, "fair");
    cur_tbl = fair_tbl;
    compare_log("fair");

    // ---------- tile_start during DRAIN, rr_ptr continuation ----------
    clear_upstream();
    start_tile();
    check("rot first col_read", 64'(col_read), 64'h8);
    wait_log(5, "rot");
    tile_start = 1'b1;
    step(1);
    tile_start = 1'b0;
    wait_done(100, "rot");
    cur_tbl = rot_tbl;
    compare_log("rot");

    // ---------- sparse arrival on column 2 ----------
    clear_upstream();
    sparse = 1'b1;
    start_tile();
    wait_done(300, "sparse");
    sparse = 1'b0;
    check("sparse count", 64'(log_q.size()), 64'(NRES));
    for (int c = 0; c < COLS; c++) next_row[c] = 0;
    for (int k = 0; k < log_q.size(); k++) begin
      check($sformatf("sparse[%0d] row order", k), 64'(log_q[k].row), 64'(next_row[log_q[k].col]));
      check($sformatf("sparse[%0d] data", k), 64'(log_q[k].data),
            64'(32'h100 * log_q[k].col + log_q[k].row));
      next_row[log_q[k].col]++;
    end
    for (int c = 0; c < COLS; c++)
      check($sformatf("sparse col %0d rows", c), 64'(next_row[c]), 64'(ROWS));

    // ---------- async reset mid-tile ----------
    clear_upstream();
    start_tile();
    wait_log(10, "arst");
    #2;
    rstn = 1'b0;
    #1;
    check("arst out_valid", 64'(out_valid), 64'd0);
    check("arst col_read", 64'(col_read), 64'd0);
    check("arst busy", 64'(busy), 64'd0);
    check("arst tile_done", 64'(tile_done), 64'd0);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    step(1);
    check("arst idle after release", 64'(busy), 64'd0);
    check("arst no done", 64'(done_cnt), 64'd0);
    clear_upstream();
    start_tile();
    check("arst rr_ptr reset col_read", 64'(col_read), 64'h1);
    wait_done(100, "arst");
    cur_tbl = basic_tbl;
    compare_log("arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
